// File: rtl/gru_sequence_ctrl.sv
// gru_sequence_ctrl
//   Recurrent sequencer around a combinational GRU cell. It takes one X word
//   per step over a valid/ready handshake, drives the cell's X and h_in ports
//   from registers, and waits SETTLE_CYCLES cycles for the cell to settle. It
//   then captures h_out, feeds it back as the next h_in and presents it
//   downstream. One start command runs one sequence of seq_len steps.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, abort            sequence control (start sampled only in IDLE)
//   seq_len, h_init         sequence length / initial hidden state, latched on start
//   x_valid, x_data, x_ready   input X stream
//   cell_x, cell_h_in       registered drive into the cell
//   cell_h_out              cell result
//   h_valid, h_data, h_last, h_ready   output hidden-state stream
//   step_idx, busy, done    status (done is a one-cycle pulse)
module gru_sequence_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int FRACT_WIDTH   = 5,
   parameter int SEQ_LEN_W     = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [SEQ_LEN_W-1:0]  seq_len,
   input  logic [DATA_WIDTH-1:0] h_init,
   input  logic                  x_valid,
   input  logic [DATA_WIDTH-1:0] x_data,
   output logic                  x_ready,
   output logic [DATA_WIDTH-1:0] cell_x,
   output logic [DATA_WIDTH-1:0] cell_h_in,
   input  logic [DATA_WIDTH-1:0] cell_h_out,
   output logic                  h_valid,
   output logic [DATA_WIDTH-1:0] h_data,
   output logic                  h_last,
   input  logic                  h_ready,
   output logic [SEQ_LEN_W-1:0]  step_idx,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   // The fixed-point format is only carried through; reject nonsensical setups.
   if (FRACT_WIDTH >= DATA_WIDTH || SETTLE_CYCLES < 1) begin : g_bad_param
      $error("gru_sequence_ctrl: invalid FRACT_WIDTH or SETTLE_CYCLES");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_X = 2'd1,
      SETTLE = 2'd2,
      EMIT   = 2'd3
   } state_t;

   state_t                state_q,  state_d;
   logic [SEQ_LEN_W-1:0]  len_q,    len_d;
   logic [SEQ_LEN_W-1:0]  step_q,   step_d;
   logic [CNT_W-1:0]      settle_q, settle_d;
   logic [DATA_WIDTH-1:0] x_reg_q,  x_reg_d;
   logic [DATA_WIDTH-1:0] h_reg_q,  h_reg_d;
   logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
   logic                  done_q,   done_d;
   logic                  last_step;

   // Comparing against len-1 (len is never 0 while busy) lets the maximum
   // length run to completion without step_idx ever wrapping.
   assign last_step = (step_q == len_q - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         len_q    <= '0;
         step_q   <= '0;
         settle_q <= '0;
         x_reg_q  <= '0;
         h_reg_q  <= '0;
         h_data_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         step_q   <= step_d;
         settle_q <= settle_d;
         x_reg_q  <= x_reg_d;
         h_reg_q  <= h_reg_d;
         h_data_q <= h_data_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      step_d   = step_q;
      settle_d = settle_q;
      x_reg_d  = x_reg_q;
      h_reg_d  = h_reg_q;
      h_data_d = h_data_q;
      done_d   = 1'b0;

      // Abort wins over everything while busy; datapath registers are left as-is.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (seq_len != '0) begin
                     len_d   = seq_len;
                     h_reg_d = h_init;
                     step_d  = '0;
                     state_d = WAIT_X;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            WAIT_X: begin
               if (x_valid) begin
                  x_reg_d  = x_data;
                  settle_d = CNT_W'(SETTLE_CYCLES - 1);
                  state_d  = SETTLE;
               end
            end
            SETTLE: begin
               if (settle_q == '0) begin
                  h_data_d = cell_h_out;
                  h_reg_d  = cell_h_out;
                  state_d  = EMIT;
               end else begin
                  settle_d = settle_q - 1'b1;
               end
            end
            EMIT: begin
               if (h_ready) begin
                  if (last_step) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     step_d  = step_q + 1'b1;
                     state_d = WAIT_X;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign x_ready   = (state_q == WAIT_X);
   assign h_valid   = (state_q == EMIT);
   assign h_last    = (state_q == EMIT) && last_step;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign h_data    = h_data_q;
   assign step_idx  = step_q;
   assign cell_x    = x_reg_q;
   assign cell_h_in = h_reg_q;

endmodule

// File: tb/tb_gru_sequence_ctrl.sv
module tb_gru_sequence_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, abort;
   logic [7:0] seq_len, h_init;
   logic       x_valid;
   logic [7:0] x_data;
   logic       x_ready;
   logic [7:0] cell_x, cell_h_in, cell_h_out;
   logic       h_valid;
   logic [7:0] h_data;
   logic       h_last, h_ready;
   logic [7:0] step_idx;
   logic       busy, done;

   int tests  = 0;
   int failed = 0;
   int done_seen = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic [7:0] s;
   } exp_t;
   exp_t sb[$];
   logic [7:0] h_model;

   always #5 clk = ~clk;

   // cell stub: h_out = x + h_in, 8-bit wrap
   assign cell_h_out = cell_x + cell_h_in;

   gru_sequence_ctrl #(
      .DATA_WIDTH(8), .FRACT_WIDTH(5), .SEQ_LEN_W(8), .SETTLE_CYCLES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .seq_len(seq_len), .h_init(h_init),
      .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
      .cell_x(cell_x), .cell_h_in(cell_h_in), .cell_h_out(cell_h_out),
      .h_valid(h_valid), .h_data(h_data), .h_last(h_last), .h_ready(h_ready),
      .step_idx(step_idx), .busy(busy), .done(done)
   );

   function automatic void check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // monitor: pop an expectation on every output handshake
   always @(negedge clk) begin
      if (rst_n && h_valid && h_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", int'(h_data), -1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("h_data", int'(h_data), int'(e.d));
            check("h_last", int'(h_last), int'(e.l));
            check("step_idx", int'(step_idx), int'(e.s));
         end
      end
      if (rst_n && done) done_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_seq(input logic [7:0] len, input logic [7:0] hi);
      seq_len = len;
      h_init  = hi;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      h_model = hi;
   endtask

   // offer one X word, push the expected result, return right after the accept edge
   task automatic send_x(input logic [7:0] x, input logic last, input logic [7:0] step);
      int n;
      exp_t e;
      h_model = x + h_model;
      e.d = h_model; e.l = last; e.s = step;
      sb.push_back(e);
      x_valid = 1'b1;
      x_data  = x;
      n = 0;
      while (!x_ready && n < 50) begin
         tick();
         n++;
      end
      if (!x_ready) check("x_ready_timeout", 0, 1);
      tick();
      x_valid = 1'b0;
   endtask

   task automatic wait_hvalid();
      int n;
      n = 0;
      while (!h_valid && n < 50) begin
         tick();
         n++;
      end
      if (!h_valid) check("h_valid_timeout", 0, 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; seq_len = '0; h_init = '0;
      x_valid = 1'b0; x_data = '0; h_ready = 1'b1; h_model = '0;
      tick(); tick();

      // reset state
      check("rst_outputs", {x_ready, h_valid, h_last, busy, done}, 0);
      check("rst_h_data", h_data, 0);
      check("rst_step", step_idx, 0);
      check("rst_cell", {cell_x, cell_h_in}, 0);
      rst_n = 1'b1;
      tick();

      // 1+2: len=3 basic run with latency checks on the first step
      start_seq(8'd3, 8'h00);
      check("busy_after_start", busy, 1);
      send_x(8'h20, 1'b0, 8'd0);               // accept edge T
      check("lat_x_ready_T1", x_ready, 0);
      check("lat_h_valid_T1", h_valid, 0);
      tick();
      check("lat_h_valid_T2", h_valid, 0);
      tick();
      check("lat_h_valid_T3", h_valid, 1);     // sampled high at edge T+3
      check("lat_x_ready_T3", x_ready, 0);
      send_x(8'h10, 1'b0, 8'd1);
      send_x(8'h08, 1'b1, 8'd2);
      wait_hvalid();
      check("t1_h_last", h_last, 1);
      tick();                                   // final handshake edge
      check("t1_done", done, 1);
      check("t1_busy", busy, 0);
      tick();
      check("t1_done_pulse", done, 0);

      // 3: backpressure during step 2
      start_seq(8'd3, 8'h00);
      send_x(8'h20, 1'b0, 8'd0);
      wait_hvalid();
      tick();                                   // step 1 handshake
      h_ready = 1'b0;
      send_x(8'h10, 1'b0, 8'd1);
      wait_hvalid();
      x_valid = 1'b1;
      x_data  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         check("bp_h_data", h_data, 8'h30);
         check("bp_h_last", h_last, 0);
         check("bp_step", step_idx, 1);
         check("bp_x_ready", x_ready, 0);
         tick();
      end
      x_valid = 1'b0;
      h_ready = 1'b1;
      tick();                                   // step 2 handshake
      send_x(8'h08, 1'b1, 8'd2);
      wait_hvalid();
      tick();
      check("t3_done", done, 1);
      tick();

      // 4: zero-length sequence
      start_seq(8'd0, 8'h00);
      check("t4_done", done, 1);
      check("t4_idle", {busy, h_valid, x_ready}, 0);
      tick();
      check("t4_done_pulse", done, 0);
      check("t4_busy", busy, 0);

      // 5: async reset during SETTLE of step 1, then restart
      start_seq(8'd3, 8'h00);
      send_x(8'h20, 1'b0, 8'd0);               // now in SETTLE
      #1 rst_n = 1'b0;
      #1;
      check("t5_rst_ctrl", {x_ready, h_valid, h_last, busy, done}, 0);
      check("t5_rst_h_data", h_data, 0);
      check("t5_rst_cell", {cell_x, cell_h_in}, 0);
      check("t5_rst_step", step_idx, 0);
      sb.delete();
      tick();
      rst_n = 1'b1;
      tick();
      check("t5_idle_after_rst", busy, 0);
      start_seq(8'd1, 8'h10);
      send_x(8'h01, 1'b1, 8'd0);
      wait_hvalid();
      check("t5_h_data", h_data, 8'h11);
      check("t5_h_last", h_last, 1);
      tick();
      check("t5_done", done, 1);
      tick();

      // 6: abort in EMIT with start high in the same cycle
      start_seq(8'd3, 8'h00);
      h_ready = 1'b0;
      send_x(8'h20, 1'b0, 8'd0);
      wait_hvalid();
      sb.delete();                              // this step is never handed over
      abort = 1'b1; start = 1'b1; seq_len = 8'd1; h_init = 8'h40;
      tick();
      check("t6_abort_busy", busy, 0);
      check("t6_abort_hv", h_valid, 0);
      check("t6_abort_done", done, 0);
      check("t6_abort_xr", x_ready, 0);
      check("t6_hold_h_data", h_data, 8'h20);
      check("t6_hold_h_reg", cell_h_in, 8'h20);
      abort = 1'b0;
      tick();                                   // start honoured here
      check("t6_restart_busy", busy, 1);
      check("t6_restart_xr", x_ready, 1);
      check("t6_restart_done", done, 0);
      start = 1'b0;
      h_ready = 1'b1;
      h_model = 8'h40;
      send_x(8'h02, 1'b1, 8'd0);
      wait_hvalid();
      tick();
      check("t6_done", done, 1);
      tick(); tick();

      check("sb_empty", sb.size(), 0);
      check("done_count", done_seen, 5);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
